// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder slice.
// Holds the FSM encoding, byte width and default sizing.
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEPTH_DEF     = 16;
    localparam int BUSY_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with occupancy count and dropped-write pulse.
// A write while full is still taken when a pop frees a slot.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [BYTE_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [BYTE_W-1:0]      rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign do_pop   = rd_en && !empty;
    assign do_push  = wr_en && (!full || do_pop);
    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign overflow = wr_en && full && !do_pop;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains a byte FIFO into a UART transmitter, one start pulse per byte.
// Completion is seen via tx_busy, or forced after BUSY_WAIT idle cycles.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BUSY_WAIT = BUSY_WAIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [BYTE_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   tx_start_transmission,
    output logic [BYTE_W-1:0]      tx_data,
    input  logic                   tx_busy,
    output logic                   sent_tick
);

    localparam int TW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(BUSY_WAIT - 1);

    tx_state_t     state_q;
    tx_state_t     state_d;
    logic          pop;
    byte_t         head;
    byte_t         data_q;
    logic [TW-1:0] wait_cnt;
    logic          wait_clr;
    logic          wait_inc;
    logic          tick_d;
    logic          tick_q;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        wait_clr = 1'b0;
        wait_inc = 1'b0;
        tick_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wait_clr = 1'b1;
                state_d  = ST_WAIT_BUSY;
            end
            // A busy seen on the last allowed cycle still wins over timeout.
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = ST_IDLE;
                    tick_d  = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                    tick_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            wait_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            if (pop) begin
                data_q <= head;
            end
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign tx_start_transmission = (state_q == ST_START);
    assign tx_data               = data_q;
    assign sent_tick             = tick_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder against a queue/timeline model.
// The transmitter's busy line is driven from the model's own schedule.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int BW    = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start_transmission;
    logic [7:0] tx_data;
    logic       sent_tick;

    uart_tx_feeder #(
        .DEPTH     (DEPTH),
        .BUSY_WAIT (BW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .wr_en                 (wr_en),
        .wr_data               (wr_data),
        .full                  (full),
        .empty                 (empty),
        .count                 (count),
        .overflow              (overflow),
        .tx_start_transmission (tx_start_transmission),
        .tx_data               (tx_data),
        .tx_busy               (tx_busy),
        .sent_tick             (sent_tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: byte queue plus the timeline of the byte in flight.
    logic [7:0] q[$];
    logic [7:0] cur    = 8'h00;
    bit         act    = 1'b0;
    int         n      = 0;
    int         s_cyc  = 0;
    int         done_c = 0;
    bit         p_never;
    int         p_d;
    int         p_len;
    int         k_mode = 0;
    int         k_d    = 0;
    int         k_len  = 1;
    int         ticks  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    function automatic void plan();
        case (k_mode)
            1: begin
                p_never = 1'b0;
                p_d     = k_d;
                p_len   = k_len;
            end
            2: begin
                p_never = 1'b1;
                p_d     = 0;
                p_len   = 0;
            end
            default: begin
                p_never = ($urandom_range(0, 3) == 0);
                p_d     = $urandom_range(0, BW - 1);
                p_len   = $urandom_range(1, 6);
            end
        endcase
        done_c = p_never ? s_cyc + 1 + BW : s_cyc + 2 + p_d + p_len;
    endfunction

    function automatic bit busy_now();
        return act && !p_never && n >= s_cyc + 1 + p_d
               && n <= s_cyc + p_d + p_len;
    endfunction

    task automatic step(input bit we, input logic [7:0] wd);
        bit exp_tick;
        bit pop_now;
        @(posedge clk);
        n++;
        #1;
        exp_tick = 1'b0;
        if (act && n == done_c) begin
            act      = 1'b0;
            exp_tick = 1'b1;
        end
        pop_now = !act && q.size() > 0;
        wr_en   = we;
        wr_data = wd;
        tx_busy = busy_now();
        @(negedge clk);
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow),
              32'(we && q.size() == DEPTH && !pop_now));
        check("start", 32'(tx_start_transmission), 32'(act && n == s_cyc));
        check("sent_tick", 32'(sent_tick), 32'(exp_tick));
        check("tx_data", 32'(tx_data), 32'(cur));
        if (sent_tick) ticks++;
        if (pop_now) begin
            cur   = q.pop_front();
            act   = 1'b1;
            s_cyc = n + 1;
            plan();
        end
        if (we && q.size() < DEPTH) q.push_back(wd);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_start"}, 32'(tx_start_transmission), 0);
        check({tag, "_data"}, 32'(tx_data), 0);
        check({tag, "_tick"}, 32'(sent_tick), 0);
    endtask

    task automatic apply_reset_mid_cycle();
        @(posedge clk);
        n++;
        #2;
        wr_en   = 1'b0;
        tx_busy = 1'b0;
        reset   = 1'b1;
        #1;
        check_reset_values("rst_mid");
        q.delete();
        act = 1'b0;
        cur = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        int t0;
        bit ok;
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("rst_init");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        k_mode = 1; k_d = 0; k_len = 160;
        t0 = ticks;
        step(1'b1, 8'hA5);
        repeat (170) step(1'b0, 8'h00);
        check("a5_ticks", 32'(ticks - t0), 1);

        k_mode = 1; k_d = 1; k_len = 40;
        for (int i = 1; i <= 18; i++) step(1'b1, 8'(i));
        for (int i = 0; i < 50; i++) step(1'b1, 8'(8'h40 + i));

        k_mode = 2;
        repeat (150) step(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i));
        repeat (40) step(1'b0, 8'h00);

        k_mode = 0;
        for (int i = 0; i < 1200; i++)
            step($urandom_range(0, 1) == 1, 8'($urandom));
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 7) == 0, 8'($urandom));
        repeat (120) step(1'b0, 8'h00);

        k_mode = 1; k_d = 0; k_len = 100;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i));
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (act && q.size() == 3 && n + 1 >= s_cyc + 2 + p_d
                && n + 1 < done_c)
                ok = 1'b1;
            else
                step(1'b0, 8'h00);
        end
        check("rst_setup", 32'(ok), 1);
        apply_reset_mid_cycle();
        t0 = ticks;
        repeat (40) step(1'b0, 8'h00);
        check("post_rst_ticks", 32'(ticks - t0), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
